// File: rtl/noise_eater_pkg.sv
// Shared types and saturating arithmetic helpers for the noise eater PI servo.
package noise_eater_pkg;

  // Conversion sequencer states
  typedef enum logic [2:0] {
    ST_ARST = 3'd0,
    ST_CNV  = 3'd1,
    ST_WAIT = 3'd2,
    ST_READ = 3'd3,
    ST_CALC = 3'd4,
    ST_UPD  = 3'd5
  } seq_state_e;

  // Datapath intermediates are carried at this width and clamped back to
  // the accumulator width; it comfortably holds err <<< 15 for 16-bit ADCs.
  localparam int unsigned WIDE_W = 64;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [WIDE_W-1:0] sat_to(input logic signed [WIDE_W-1:0] v,
                                                       input int unsigned w);
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      sat_to = hi;
    else if (v < lo) sat_to = lo;
    else             sat_to = v;
  endfunction

  // Signed saturating add, result limited to a w-bit signed range.
  function automatic logic signed [WIDE_W-1:0] sat_add(input logic signed [WIDE_W-1:0] a,
                                                        input logic signed [WIDE_W-1:0] b,
                                                        input int unsigned w);
    sat_add = sat_to(a + b, w);
  endfunction

endpackage

// File: rtl/noise_eater_pi_adc_seq.sv
// SAR ADC conversion sequencer: reset, convert, wait for EOC, read, then
// hands the sample to the PI datapath and waits out its CALC/UPD slots.
//
//   state | meaning
//   ARST  | ADC_RST high for ARST_CYC cycles (after reset or EOC timeout)
//   CNV   | ADC_CNVST low for CNVST_CYC cycles
//   WAIT  | poll ADC_EOC, give up after EOC_TIMEOUT cycles
//   READ  | CS/RD low for RD_CYC cycles, sample latched on the last one
//   CALC  | datapath computes the new DAC word (sample_valid_o high)
//   UPD   | datapath commits the DAC word (upd_o high)
module adc_seq
  import noise_eater_pkg::*;
#(
  parameter int ADC_W       = 16,
  parameter int CNVST_CYC   = 2,
  parameter int RD_CYC      = 2,
  parameter int EOC_TIMEOUT = 255,
  parameter int ARST_CYC    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adc_eoc_i,
  input  logic [ADC_W-1:0] adc_data_i,
  output logic             adc_rst_o,
  output logic             adc_cnvst_o,
  output logic             adc_cs_o,
  output logic             adc_rd_o,
  output logic [ADC_W-1:0] sample_o,
  output logic             sample_valid_o,
  output logic             upd_o,
  output logic             timeout_o
);

  localparam int CNT_MAX_A = (ARST_CYC > CNVST_CYC) ? ARST_CYC : CNVST_CYC;
  localparam int CNT_MAX_B = (RD_CYC > EOC_TIMEOUT) ? RD_CYC : EOC_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             adc_rst_q, cnvst_q, cs_q, rd_q;
  logic [ADC_W-1:0] sample_q;
  logic             sample_valid_q, upd_q, timeout_q;

  // Sequencer FSM with down-counter phase timing; every output is registered.
  // EOC is sampled directly so an EOC already low on WAIT entry is taken at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_ARST;
      cnt_q          <= CNT_W'(ARST_CYC - 1);
      adc_rst_q      <= 1'b1;
      cnvst_q        <= 1'b1;
      cs_q           <= 1'b1;
      rd_q           <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      upd_q          <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      upd_q          <= 1'b0;
      unique case (state_q)
        ST_ARST: begin
          if (cnt_q == '0) begin
            state_q   <= ST_CNV;
            adc_rst_q <= 1'b0;
            cnvst_q   <= 1'b0;
            cnt_q     <= CNT_W'(CNVST_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CNV: begin
          if (cnt_q == '0) begin
            state_q <= ST_WAIT;
            cnvst_q <= 1'b1;
            cnt_q   <= CNT_W'(EOC_TIMEOUT - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_WAIT: begin
          if (!adc_eoc_i) begin
            state_q <= ST_READ;
            cs_q    <= 1'b0;
            rd_q    <= 1'b0;
            cnt_q   <= CNT_W'(RD_CYC - 1);
          end else if (cnt_q == '0) begin
            state_q   <= ST_ARST;
            timeout_q <= 1'b1;
            adc_rst_q <= 1'b1;
            cnt_q     <= CNT_W'(ARST_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_READ: begin
          if (cnt_q == '0) begin
            state_q        <= ST_CALC;
            sample_q       <= adc_data_i;
            sample_valid_q <= 1'b1;
            cs_q           <= 1'b1;
            rd_q           <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_CALC: begin
          state_q <= ST_UPD;
          upd_q   <= 1'b1;
        end
        ST_UPD: begin
          state_q <= ST_CNV;
          cnvst_q <= 1'b0;
          cnt_q   <= CNT_W'(CNVST_CYC - 1);
        end
        default: begin
          state_q   <= ST_ARST;
          adc_rst_q <= 1'b1;
          cnt_q     <= CNT_W'(ARST_CYC - 1);
        end
      endcase
    end
  end

  assign adc_rst_o      = adc_rst_q;
  assign adc_cnvst_o    = cnvst_q;
  assign adc_cs_o       = cs_q;
  assign adc_rd_o       = rd_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign upd_o          = upd_q;
  assign timeout_o      = timeout_q;

endmodule

// File: rtl/noise_eater_pi.sv
// PI intensity servo: ADC sample -> error -> shift-gain PI with saturation
// and anti-windup -> offset-binary DAC word, one update per conversion.
module noise_eater_pi
  import noise_eater_pkg::*;
#(
  parameter int ADC_W       = 16,
  parameter int DAC_W       = 16,
  parameter int ACC_W       = 24,
  parameter int CNVST_CYC   = 2,
  parameter int RD_CYC      = 2,
  parameter int EOC_TIMEOUT = 255,
  parameter int ARST_CYC    = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HOLD,
  input  logic [ADC_W-1:0] SETPOINT,
  input  logic [3:0]       KP_SHIFT,
  input  logic [3:0]       KI_SHIFT,
  output logic             ADC_RST,
  output logic             ADC_CNVST,
  input  logic             ADC_EOC,
  output logic             ADC_CS,
  output logic             ADC_RD,
  input  logic [ADC_W-1:0] ADC_DATA,
  output logic [DAC_W-1:0] DAC_DATA,
  output logic             DAC_VALID,
  output logic             SAT,
  output logic             TIMEOUT_ERR
);

  localparam int SH = ACC_W - DAC_W - 2;
  localparam logic signed [WIDE_W-1:0] Y_MAX = (64'sd1 <<< (DAC_W - 1)) - 64'sd1;
  localparam logic signed [WIDE_W-1:0] Y_MIN = -(64'sd1 <<< (DAC_W - 1));
  localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};

  logic [ADC_W-1:0] sample;
  logic             sample_valid, upd;

  adc_seq #(
    .ADC_W      (ADC_W),
    .CNVST_CYC  (CNVST_CYC),
    .RD_CYC     (RD_CYC),
    .EOC_TIMEOUT(EOC_TIMEOUT),
    .ARST_CYC   (ARST_CYC)
  ) u_seq (
    .clk_i         (CLK),
    .rst_i         (RST),
    .adc_eoc_i     (ADC_EOC),
    .adc_data_i    (ADC_DATA),
    .adc_rst_o     (ADC_RST),
    .adc_cnvst_o   (ADC_CNVST),
    .adc_cs_o      (ADC_CS),
    .adc_rd_o      (ADC_RD),
    .sample_o      (sample),
    .sample_valid_o(sample_valid),
    .upd_o         (upd),
    .timeout_o     (TIMEOUT_ERR)
  );

  logic signed [ACC_W-1:0]  integ_q, integ_pend_q;
  logic [DAC_W-1:0]         word_q, dac_q;
  logic                     sat_pend_q, sat_q, valid_q;

  logic signed [ADC_W:0]    err;
  logic signed [WIDE_W-1:0] err_w, p_w, inc_w, i_next_w, sum_w, y_w;
  logic                     clamp_hi, clamp_lo, err_pos, err_neg, freeze_integ;
  logic [DAC_W-1:0]         word_d;
  logic signed [ACC_W-1:0]  integ_d;

  assign err = $signed({1'b0, SETPOINT}) - $signed({1'b0, sample});

  // PI arithmetic, evaluated against the sample held during CALC.
  always_comb begin
    err_w        = WIDE_W'(err);
    p_w          = sat_to(err_w <<< KP_SHIFT, ACC_W);
    inc_w        = err_w >>> KI_SHIFT;
    i_next_w     = sat_add(WIDE_W'(integ_q), inc_w, ACC_W);
    sum_w        = sat_add(p_w, i_next_w, ACC_W);
    y_w          = sum_w >>> SH;
    clamp_hi     = (y_w > Y_MAX);
    clamp_lo     = (y_w < Y_MIN);
    err_pos      = !err[ADC_W] && (err != '0);
    err_neg      = err[ADC_W];
    // Stop integrating into a rail; error pulling off the rail still integrates.
    freeze_integ = (clamp_hi && err_pos) || (clamp_lo && err_neg);
    integ_d      = freeze_integ ? integ_q : i_next_w[ACC_W-1:0];
    if (clamp_hi)      word_d = '1;
    else if (clamp_lo) word_d = '0;
    else               word_d = {~y_w[DAC_W-1], y_w[DAC_W-2:0]};
  end

  // Capture the CALC result; setpoint and gains are only looked at here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      word_q       <= DAC_MID;
      integ_pend_q <= '0;
      sat_pend_q   <= 1'b0;
    end else if (sample_valid) begin
      word_q       <= word_d;
      integ_pend_q <= integ_d;
      sat_pend_q   <= clamp_hi || clamp_lo;
    end
  end

  // Commit in UPD unless HOLD freezes the loop (integrator, DAC and SAT keep state).
  always_ff @(posedge CLK) begin
    if (RST) begin
      dac_q   <= DAC_MID;
      integ_q <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (upd && !HOLD) begin
      dac_q   <= word_q;
      integ_q <= integ_pend_q;
      sat_q   <= sat_pend_q;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign DAC_DATA  = dac_q;
  assign DAC_VALID = valid_q;
  assign SAT       = sat_q;

endmodule
